// File: rtl/multicycle_arithmetic_unit.sv
// Multicycle arithmetic unit: ADD/SUB in one cycle, shift-add MUL and
// restoring DIV over WIDTH cycles, with a start/busy/done handshake.
module multicycle_arithmetic_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           operation,
  input  logic [WIDTH-1:0]     operand_1,
  input  logic [WIDTH-1:0]     operand_2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               state;
  logic [1:0]           op_q;
  // a_q: multiplier (shifts right) for MUL, dividend/quotient (shifts left) for DIV
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     rem_q;
  logic [CW-1:0]        cnt_q;

  logic [2*WIDTH-1:0]   add_res, sub_res, mul_acc_nx;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_df, rem_nx, quo_nx;
  logic                 div_ge, last, b_zero, short_op;

  // One iteration of each multicycle algorithm plus the single-cycle results
  always_comb begin
    add_res    = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
    sub_res    = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
    mul_acc_nx = acc_q + (a_q[0] ? mcand_q : '0);
    rem_sh     = {rem_q, a_q[WIDTH-1]};
    div_ge     = (rem_sh >= {1'b0, b_q});
    // when div_ge holds the difference is below 2^WIDTH, so WIDTH bits suffice
    rem_df     = rem_sh[WIDTH-1:0] - b_q;
    rem_nx     = div_ge ? rem_df : rem_sh[WIDTH-1:0];
    quo_nx     = {a_q[WIDTH-2:0], div_ge};
    last       = (cnt_q == CW'(WIDTH-1));
    b_zero     = (b_q == '0);
    short_op   = (op_q == OP_ADD) || (op_q == OP_SUB) || ((op_q == OP_DIV) && b_zero);
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q        <= operation;
            a_q         <= operand_1;
            b_q         <= operand_2;
            mcand_q     <= {{WIDTH{1'b0}}, operand_2};
            acc_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CALC;
          end
        end
        S_CALC: begin
          if (short_op) begin
            case (op_q)
              OP_ADD:  result <= add_res;
              OP_SUB:  result <= sub_res;
              default: result <= {a_q, {WIDTH{1'b1}}};
            endcase
            div_by_zero <= (op_q == OP_DIV);
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            if (op_q == OP_MUL) begin
              acc_q   <= mul_acc_nx;
              a_q     <= a_q >> 1;
              mcand_q <= mcand_q << 1;
            end else begin
              rem_q <= rem_nx;
              a_q   <= quo_nx;
            end
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              result <= (op_q == OP_MUL) ? mul_acc_nx : {rem_nx, quo_nx};
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_arithmetic_unit.sv
// Directed bench for multicycle_arithmetic_unit (WIDTH=8).
module tb_multicycle_arithmetic_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic [7:0]  operand_1 = '0;
  logic [7:0]  operand_2 = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  multicycle_arithmetic_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .operand_1(operand_1), .operand_2(operand_2),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after the start edge, measure latency and result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat,
                       input logic [15:0] exp_res, input logic exp_dbz);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; operation = ~op; operand_1 = ~a; operand_2 = b ^ 8'h5A;
    chk({tag, " busy_e0"}, busy, 1);
    chk({tag, " dbz_clr"}, div_by_zero, 0);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " dbz"}, div_by_zero, exp_dbz);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_low"}, done, 0);
    chk({tag, " busy_low"}, busy, 0);
    chk({tag, " held"}, result, exp_res);
  endtask

  initial begin
    int ndone;
    logic [15:0] first_res;
    bit seen;
    int n;

    // reset state
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op("add200_100", 2'b00, 8'd200, 8'd100, 1, 16'h012C, 0);
    do_op("add255_255", 2'b00, 8'd255, 8'd255, 1, 16'h01FE, 0);
    do_op("sub5_7",     2'b01, 8'd5,   8'd7,   1, 16'hFFFE, 0);
    do_op("sub7_5",     2'b01, 8'd7,   8'd5,   1, 16'h0002, 0);
    do_op("mul255_255", 2'b10, 8'd255, 8'd255, 8, 16'hFE01, 0);
    do_op("mul0_173",   2'b10, 8'd0,   8'd173, 8, 16'h0000, 0);
    do_op("mul12_13",   2'b10, 8'd12,  8'd13,  8, 16'h009C, 0);
    do_op("div200_7",   2'b11, 8'd200, 8'd7,   8, 16'h041C, 0);
    do_op("div5_0",     2'b11, 8'd5,   8'd0,   1, 16'h05FF, 1);
    do_op("div255_1",   2'b11, 8'd255, 8'd1,   8, 16'h00FF, 0);
    do_op("div3_9",     2'b11, 8'd3,   8'd9,   8, 16'h0300, 0);

    // start held high through a MUL with changing operands
    @(negedge clk);
    start = 1'b1; operation = 2'b10; operand_1 = 8'd12; operand_2 = 8'd13;
    @(posedge clk);
    ndone = 0; first_res = '0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin ndone++; first_res = result; end
      operand_1 = 8'(k); operand_2 = 8'(k);
    end
    chk("hold done_cnt", ndone, 1);
    chk("hold result", first_res, 16'h009C);
    chk("hold idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold reaccept", busy, 1);
    start = 1'b0; operand_1 = 8'hAA; operand_2 = 8'h33;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("hold2 latency", n, 8);
    chk("hold2 result", result, 16'h0051);
    @(posedge clk);

    // async reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; operation = 2'b11; operand_1 = 8'd200; operand_2 = 8'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst result", result, 0);
    chk("arst dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst no_done", ndone, 0);
    do_op("add1_1", 2'b00, 8'd1, 8'd1, 1, 16'h0002, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
